reorder_tag_forwarder: RTL and testbench
========================================

Name: reorder_tag_forwarder

Overview:
Transmit-side partner of the packet reorder circular buffer. Accepts AXI-Stream packets from the filter input and stamps each packet with a sequential reorder tag. Forwards the beats, tag and TLAST to the circular buffer's write port, honouring the buffer's TREADY and fwd_rdy. Tracks outstanding tags, so a tag is never reissued until the buffer's read side releases it. Enforces the per-packet beat limit.

Parameters:
TAG_WIDTH, 6, width of the reorder tag
CIRCULAR_BUFFER_SIZE, 50, number of tag slots; tags wrap from CIRCULAR_BUFFER_SIZE-1 to 0
DATA_WIDTH, 64, TDATA width
MAX_TDATA_PER_PACKET, 256, maximum beats stored per packet

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
s_TDATA  in  DATA_WIDTH  input stream data
s_TLAST  in  1  input end of packet
s_TVALID  in  1  input beat valid
s_TREADY  out  1  input beat accepted
buffer_TDATA  out  DATA_WIDTH  data to circular buffer
reorder_tag_out  out  TAG_WIDTH  tag of the current packet; constant for all beats of a packet
buffer_TLAST  out  1  end of packet to buffer
buffer_TVALID  out  1  beat valid to buffer
buffer_TREADY  in  1  buffer accepts beat
fwd_rdy  in  1  buffer has packet space
tag_release_valid  in  1  one-cycle pulse: buffer read pointer has advanced past one tag (packet sent or rejected)
outstanding  out  TAG_WIDTH+1  number of tags in flight, 0..CIRCULAR_BUFFER_SIZE
err_overlen  out  1  one-cycle pulse: packet truncated
err_release  out  1  one-cycle pulse: release received with outstanding==0

Behaviour:
- Reset (async assert, sync release): state=IDLE, next_tag=0, outstanding=0, beat_cnt=0, output register empty. All outputs are 0 during reset, including s_TREADY.
- Output transfer: out_xfer = buffer_TVALID & buffer_TREADY & fwd_rdy. The output register holds TDATA/TLAST/tag stable while buffer_TVALID=1 and out_xfer=0.
- Input accept: in_xfer = s_TVALID & s_TREADY.
- s_TREADY = (!buffer_TVALID | out_xfer) & state_ok, where state_ok is:
  - IDLE: outstanding < CIRCULAR_BUFFER_SIZE
  - STREAM: 1
  - DRAIN: 1
- Latency: a beat accepted in cycle N appears on buffer_* in cycle N+1.
- FSM IDLE:
  - in_xfer allocates a tag: reorder tag = next_tag, next_tag wraps at CIRCULAR_BUFFER_SIZE-1 to 0, outstanding +1.
  - beat_cnt=1; the beat is loaded.
  - If s_TLAST, stay in IDLE; otherwise go to STREAM.
- FSM STREAM:
  - Each in_xfer loads the beat and increments beat_cnt.
  - If s_TLAST, go to IDLE.
  - Else if beat_cnt reaches MAX_TDATA_PER_PACKET on this beat: force buffer_TLAST=1, pulse err_overlen, go to DRAIN.
- FSM DRAIN:
  - Accept and discard input beats; no output is loaded.
  - On the s_TLAST beat, go to IDLE.
- Tag accounting:
  - Allocation and release in the same cycle leaves outstanding unchanged.
  - Release with outstanding==0 is ignored and pulses err_release.
  - When outstanding==CIRCULAR_BUFFER_SIZE, IDLE stalls with s_TREADY=0. A release lifts the stall: s_TREADY rises combinationally that cycle, since outstanding decrements next cycle.
- Widths: beat_cnt is $clog2(MAX_TDATA_PER_PACKET)+1 bits. next_tag compare uses TAG_WIDTH bits.
- fwd_rdy=0 blocks output transfer only. It never corrupts held data.
- Reset asserted mid-packet: the in-flight packet and all tag state are discarded. The buffer is reset on the same rst_n.

Decomposition:
- Shared package: TAG_WIDTH, CIRCULAR_BUFFER_SIZE, DATA_WIDTH, MAX_TDATA_PER_PACKET defaults; FSM state encoding (IDLE=0, STREAM=1, DRAIN=2).
- One natural sub-module: tag_allocator (next_tag wrap counter + outstanding credit counter + err_release). Main module keeps the FSM and output register.

Test Plan:
- Three 4-beat packets, buffer_TREADY=fwd_rdy=1 -> tags 0,1,2; each buffer_TLAST on the 4th beat; outstanding=3; 1-cycle latency.
- 50 single-beat packets with no release -> tags 0..49, outstanding=50, s_TREADY=0 on the 51st. Then one tag_release_valid pulse -> 51st packet accepted with tag 0.
- buffer_TREADY toggling 1010 during a 6-beat packet -> TDATA/tag held stable while stalled; all 6 beats delivered in order, no duplicates.
- 300-beat packet -> 256 beats forwarded, buffer_TLAST on beat 256, err_overlen pulse, 44 beats dropped; next packet gets the next tag.
- Allocation and release in the same cycle with outstanding=5 -> outstanding stays 5. Release at outstanding=0 -> err_release pulse, outstanding stays 0.
- rst_n asserted mid-packet (beat 3 of 8) -> buffer_TVALID=0 and outstanding=0 immediately; after release, first packet gets tag 0.

Source files
------------

// File: rtl/reorder_tag_forwarder_pkg.sv
// Shared defaults and FSM encoding for the reorder tag forwarder.
package reorder_tag_forwarder_pkg;

    localparam int DEF_TAG_WIDTH            = 6;
    localparam int DEF_CIRCULAR_BUFFER_SIZE = 50;
    localparam int DEF_DATA_WIDTH           = 64;
    localparam int DEF_MAX_TDATA_PER_PACKET = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } fwd_state_e;

    // One extra bit so the count can hold the limit itself.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats) + 1;
    endfunction

endpackage

// File: rtl/reorder_tag_forwarder_if.sv
// Stream bundle between the filter input, the forwarder and the circular buffer write port.
interface reorder_tag_forwarder_if
    import reorder_tag_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
);
    logic [DATA_WIDTH-1:0] s_TDATA;
    logic                  s_TLAST;
    logic                  s_TVALID;
    logic                  s_TREADY;

    logic [DATA_WIDTH-1:0] buffer_TDATA;
    logic [TAG_WIDTH-1:0]  reorder_tag_out;
    logic                  buffer_TLAST;
    logic                  buffer_TVALID;
    logic                  buffer_TREADY;
    logic                  fwd_rdy;

    // Forwarder side.
    modport master (
        input  s_TDATA, s_TLAST, s_TVALID, buffer_TREADY, fwd_rdy,
        output s_TREADY, buffer_TDATA, reorder_tag_out, buffer_TLAST, buffer_TVALID
    );

    // Environment side: filter source and circular buffer sink.
    modport slave (
        output s_TDATA, s_TLAST, s_TVALID, buffer_TREADY, fwd_rdy,
        input  s_TREADY, buffer_TDATA, reorder_tag_out, buffer_TLAST, buffer_TVALID
    );

endinterface

// File: rtl/reorder_tag_forwarder_tag_allocator.sv
// Sequential tag issue with wrap, plus the credit count of tags still held by the buffer.
module reorder_tag_forwarder_tag_allocator
    import reorder_tag_forwarder_pkg::*;
#(
    parameter int TAG_WIDTH            = DEF_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEF_CIRCULAR_BUFFER_SIZE
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc,
    input  logic                 release_valid,
    output logic [TAG_WIDTH-1:0] next_tag,
    output logic [TAG_WIDTH:0]   outstanding,
    output logic                 has_credit,
    output logic                 err_release
);
    localparam int                   OW       = TAG_WIDTH + 1;
    localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [OW-1:0]        FULL_CNT = OW'(CIRCULAR_BUFFER_SIZE);

    logic release_ok;

    // A release against an empty count is bogus and must not underflow.
    assign release_ok = release_valid && (outstanding != '0);

    // A release this cycle frees a slot for a packet start in the same cycle.
    assign has_credit = (outstanding < FULL_CNT) || release_valid;

    // Tag counter, credit counter and spurious-release flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_tag    <= '0;
            outstanding <= '0;
            err_release <= 1'b0;
        end else begin
            err_release <= release_valid && (outstanding == '0);
            if (alloc) begin
                next_tag <= (next_tag == LAST_TAG) ? '0 : next_tag + 1'b1;
            end
            case ({alloc, release_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/reorder_tag_forwarder.sv
// Stamps each input packet with a reorder tag and forwards it, one register deep, to the buffer.
module reorder_tag_forwarder
    import reorder_tag_forwarder_pkg::*;
#(
    parameter int TAG_WIDTH            = DEF_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEF_CIRCULAR_BUFFER_SIZE,
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int MAX_TDATA_PER_PACKET = DEF_MAX_TDATA_PER_PACKET
)(
    input  logic                   clk,
    input  logic                   rst_n,
    reorder_tag_forwarder_if.master bus,
    input  logic                   tag_release_valid,
    output logic [TAG_WIDTH:0]     outstanding,
    output logic                   err_overlen,
    output logic                   err_release
);
    localparam int             BCW       = beat_cnt_width(MAX_TDATA_PER_PACKET);
    localparam logic [BCW-1:0] MAX_BEATS = BCW'(MAX_TDATA_PER_PACKET);

    fwd_state_e            state;
    logic [BCW-1:0]        beat_cnt;
    logic [BCW-1:0]        beat_nxt;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  last_p1;
    logic [TAG_WIDTH-1:0]  tag_p1;
    logic                  vld_p1;

    logic [TAG_WIDTH-1:0]  next_tag;
    logic                  has_credit;
    logic                  state_ok;
    logic                  in_ready;
    logic                  out_xfer;
    logic                  in_xfer;
    logic                  alloc;

    assign out_xfer = vld_p1 & bus.buffer_TREADY & bus.fwd_rdy;
    // Only a packet start needs a free tag; mid-packet and discard beats always flow.
    assign state_ok = (state == ST_IDLE) ? has_credit : 1'b1;
    // rst_n gating keeps s_TREADY low while reset is held.
    assign in_ready = rst_n & (!vld_p1 | out_xfer) & state_ok;
    assign in_xfer  = bus.s_TVALID & in_ready;
    assign alloc    = in_xfer & (state == ST_IDLE);
    assign beat_nxt = beat_cnt + 1'b1;

    reorder_tag_forwarder_tag_allocator #(
        .TAG_WIDTH            (TAG_WIDTH),
        .CIRCULAR_BUFFER_SIZE (CIRCULAR_BUFFER_SIZE)
    ) u_tag_allocator (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc         (alloc),
        .release_valid (tag_release_valid),
        .next_tag      (next_tag),
        .outstanding   (outstanding),
        .has_credit    (has_credit),
        .err_release   (err_release)
    );

    // Packet FSM and output register: load on accept, hold until the buffer takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            data_p1     <= '0;
            last_p1     <= 1'b0;
            tag_p1      <= '0;
            vld_p1      <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            err_overlen <= 1'b0;
            if (out_xfer) begin
                vld_p1 <= 1'b0;
            end
            if (in_xfer) begin
                case (state)
                    ST_IDLE: begin
                        data_p1  <= bus.s_TDATA;
                        last_p1  <= bus.s_TLAST;
                        tag_p1   <= next_tag;
                        vld_p1   <= 1'b1;
                        beat_cnt <= BCW'(1);
                        state    <= bus.s_TLAST ? ST_IDLE : ST_STREAM;
                    end
                    ST_STREAM: begin
                        data_p1  <= bus.s_TDATA;
                        vld_p1   <= 1'b1;
                        beat_cnt <= beat_nxt;
                        if (bus.s_TLAST) begin
                            last_p1 <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (beat_nxt == MAX_BEATS) begin
                            // Truncate: close the packet here and swallow the rest.
                            last_p1     <= 1'b1;
                            err_overlen <= 1'b1;
                            state       <= ST_DRAIN;
                        end else begin
                            last_p1 <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.s_TLAST) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.s_TREADY        = in_ready;
    assign bus.buffer_TDATA    = data_p1;
    assign bus.buffer_TLAST    = last_p1;
    assign bus.reorder_tag_out = tag_p1;
    assign bus.buffer_TVALID   = vld_p1;

endmodule

// File: tb/tb_reorder_tag_forwarder.sv
// Bench for reorder_tag_forwarder: directed scenarios plus randomized traffic against a packet-level model.
module tb_reorder_tag_forwarder;

    localparam int DW   = 64;
    localparam int TW   = 6;
    localparam int SIZE = 50;
    localparam int MAXB = 256;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          tag;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tag_release_valid;
    logic [TW:0]   outstanding;
    logic          err_overlen;
    logic          err_release;

    reorder_tag_forwarder_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bif ();

    reorder_tag_forwarder #(
        .TAG_WIDTH            (TW),
        .CIRCULAR_BUFFER_SIZE (SIZE),
        .DATA_WIDTH           (DW),
        .MAX_TDATA_PER_PACKET (MAXB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bif),
        .tag_release_valid (tag_release_valid),
        .outstanding       (outstanding),
        .err_overlen       (err_overlen),
        .err_release       (err_release)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;

    // Packet-level reference model.
    beat_t expq[$];
    int    m_outst, m_next_tag, m_cur_tag, m_beats;
    bit    m_in_pkt, m_drop;
    int    exp_ovl, exp_erel, obs_ovl, obs_erel;
    int    fwd_beats;

    int    rdy_mode;
    int    rel_mode;
    bit    tog;
    bit    last_in_acc;
    bit    hold_v;
    logic [63:0] hold_d;
    logic        hold_l;
    logic [TW-1:0] hold_t;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        m_outst = 0; m_next_tag = 0; m_cur_tag = 0; m_beats = 0;
        m_in_pkt = 0; m_drop = 0;
        exp_ovl = 0; exp_erel = 0; obs_ovl = 0; obs_erel = 0;
        hold_v = 0;
    endtask

    task automatic model_beat(input logic [63:0] d, input logic l);
        beat_t b;
        if (!m_in_pkt) begin
            m_cur_tag  = m_next_tag;
            m_next_tag = (m_next_tag + 1) % SIZE;
            m_outst++;
            m_beats  = 1;
            m_drop   = 0;
            m_in_pkt = !l;
            b.d = d; b.l = l; b.tag = m_cur_tag;
            expq.push_back(b);
        end else if (m_drop) begin
            if (l) m_in_pkt = 0;
        end else begin
            m_beats++;
            b.d = d; b.tag = m_cur_tag;
            if (l) begin
                b.l = 1; m_in_pkt = 0;
            end else if (m_beats == MAXB) begin
                b.l = 1; m_drop = 1; exp_ovl++;
            end else begin
                b.l = 0;
            end
            expq.push_back(b);
        end
    endtask

    // One clock: entered just after a falling edge with inputs already set.
    task automatic cycle();
        bit    in_acc = 0;
        bit    out_acc = 0;
        bit    rel = 0;
        beat_t e;
        case (rdy_mode)
            0: begin bif.buffer_TREADY = 1'b1; bif.fwd_rdy = 1'b1; end
            1: begin bif.buffer_TREADY = tog; bif.fwd_rdy = 1'b1; tog = !tog; end
            default: begin
                bif.buffer_TREADY = ($urandom_range(0, 3) != 0);
                bif.fwd_rdy       = ($urandom_range(0, 3) != 0);
            end
        endcase
        if (rel_mode == 1) tag_release_valid = ($urandom_range(0, 4) == 0);
        #1;
        if (rst_n) begin
            in_acc  = bif.s_TVALID && bif.s_TREADY;
            out_acc = bif.buffer_TVALID && bif.buffer_TREADY && bif.fwd_rdy;
            rel     = tag_release_valid;
            chk("outstanding", outstanding, m_outst);
            if (err_overlen) obs_ovl++;
            if (err_release) obs_erel++;
            if (hold_v) begin
                chk("hold_data", bif.buffer_TDATA, hold_d);
                chk("hold_last", bif.buffer_TLAST, hold_l);
                chk("hold_tag", bif.reorder_tag_out, hold_t);
            end
            hold_v = bif.buffer_TVALID && !out_acc;
            hold_d = bif.buffer_TDATA;
            hold_l = bif.buffer_TLAST;
            hold_t = bif.reorder_tag_out;
            if (out_acc) begin
                fwd_beats++;
                chk("beat_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("out_data", bif.buffer_TDATA, e.d);
                    chk("out_last", bif.buffer_TLAST, e.l);
                    chk("out_tag", bif.reorder_tag_out, e.tag);
                end
            end
            if (rel) begin
                if (m_outst == 0) exp_erel++;
                else m_outst--;
            end
            if (in_acc) model_beat(bif.s_TDATA, bif.s_TLAST);
        end
        last_in_acc = in_acc;
        @(posedge clk);
        @(negedge clk);
        tag_release_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic l);
        int n = 0;
        bif.s_TVALID = 1'b1;
        bif.s_TDATA  = d;
        bif.s_TLAST  = l;
        do begin
            cycle();
            n++;
        end while (!last_in_acc && n < 2000);
        chk("beat_accepted", last_in_acc, 1);
        bif.s_TVALID = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            drive_beat({$urandom, $urandom}, i == n - 1);
            if (gaps && $urandom_range(0, 3) == 0) cycle();
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || bif.buffer_TVALID) && n < 5000) begin
            cycle();
            n++;
        end
        chk("drain_empty", expq.size(), 0);
        cycle();
        cycle();
    endtask

    // Asserts reset wherever the caller currently is, checks the reset outputs, releases on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        bif.s_TVALID = 1'b0;
        tag_release_valid = 1'b0;
        #1;
        chk("rst_s_tready", bif.s_TREADY, 0);
        chk("rst_buf_tvalid", bif.buffer_TVALID, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_buf_tlast", bif.buffer_TLAST, 0);
        chk("rst_tag", bif.reorder_tag_out, 0);
        chk("rst_tdata", bif.buffer_TDATA, 0);
        chk("rst_err_overlen", err_overlen, 0);
        chk("rst_err_release", err_release, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        tag_release_valid = 1'b0;
        bif.s_TVALID = 1'b0;
        bif.s_TDATA = '0;
        bif.s_TLAST = 1'b0;
        bif.buffer_TREADY = 1'b1;
        bif.fwd_rdy = 1'b1;
        rdy_mode = 0; rel_mode = 0; tog = 1; fwd_beats = 0; last_in_acc = 0;
        model_reset();
        @(negedge clk);
        #2;
        do_reset();

        // Three 4-beat packets, first beat visible one cycle after acceptance.
        drive_beat(64'h1111, 1'b0);
        chk("lat_valid", bif.buffer_TVALID, 1);
        chk("lat_data", bif.buffer_TDATA, 64'h1111);
        chk("lat_tag", bif.reorder_tag_out, 0);
        drive_beat(64'h1112, 1'b0);
        drive_beat(64'h1113, 1'b0);
        drive_beat(64'h1114, 1'b1);
        chk("lat_last", bif.buffer_TLAST, 1);
        send_pkt(4, 0);
        send_pkt(4, 0);
        drain();
        chk("three_pkts_outstanding", outstanding, 3);
        chk("three_pkts_beats", fwd_beats, 12);

        // Fill all 50 tags, stall, then a release admits the next packet with tag 0.
        @(negedge clk); #2;
        do_reset();
        for (int i = 0; i < SIZE; i++) send_pkt(1, 0);
        drain();
        chk("full_outstanding", outstanding, SIZE);
        bif.s_TVALID = 1'b1;
        bif.s_TDATA  = 64'hF00D;
        bif.s_TLAST  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("full_stall_accept", last_in_acc, 0);
            chk("full_stall_ready", bif.s_TREADY, 0);
        end
        tag_release_valid = 1'b1;
        #1;
        chk("release_lifts_ready", bif.s_TREADY, 1);
        cycle();
        chk("release_accept", last_in_acc, 1);
        bif.s_TVALID = 1'b0;
        chk("wrap_tag", bif.reorder_tag_out, 0);
        drain();
        chk("full_after_wrap", outstanding, SIZE);

        // Allocate and release together, then release with nothing outstanding.
        @(negedge clk); #2;
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(1, 0);
        drain();
        chk("five_outstanding", outstanding, 5);
        bif.s_TVALID = 1'b1;
        bif.s_TDATA  = 64'hABCD;
        bif.s_TLAST  = 1'b1;
        tag_release_valid = 1'b1;
        cycle();
        chk("same_cycle_accept", last_in_acc, 1);
        bif.s_TVALID = 1'b0;
        drain();
        chk("same_cycle_outstanding", outstanding, 5);
        for (int i = 0; i < 5; i++) begin
            tag_release_valid = 1'b1;
            cycle();
        end
        chk("released_all", outstanding, 0);
        tag_release_valid = 1'b1;
        cycle();
        cycle();
        chk("err_release_once", obs_erel, 1);
        chk("err_release_model", obs_erel, exp_erel);
        chk("zero_after_bad_release", outstanding, 0);

        // 6-beat packet with buffer_TREADY toggling 1,0,1,0...
        rdy_mode = 1; tog = 1; fwd_beats = 0;
        send_pkt(6, 0);
        drain();
        rdy_mode = 0;
        chk("toggle_beats", fwd_beats, 6);

        // 300-beat packet: 256 forwarded, truncation flagged, next packet gets the next tag.
        fwd_beats = 0;
        send_pkt(300, 0);
        drain();
        chk("overlen_beats", fwd_beats, MAXB);
        chk("overlen_pulse", obs_ovl, 1);
        chk("overlen_model", obs_ovl, exp_ovl);
        send_pkt(2, 0);
        drain();
        chk("after_overlen_outstanding", outstanding, 3);

        // Randomized traffic, back-pressure and releases.
        rdy_mode = 2; rel_mode = 1;
        for (int p = 0; p < 150; p++) begin
            if (p == 75) send_pkt(MAXB + 5, 1);
            else send_pkt($urandom_range(1, 8), 1);
        end
        rel_mode = 0;
        drain();
        rdy_mode = 0;
        chk("rand_overlen", obs_ovl, exp_ovl);
        chk("rand_err_release", obs_erel, exp_erel);

        // Reset in the middle of an 8-beat packet.
        drive_beat(64'h31, 1'b0);
        drive_beat(64'h32, 1'b0);
        drive_beat(64'h33, 1'b0);
        #2;
        do_reset();
        drive_beat(64'h41, 1'b0);
        chk("post_reset_tag", bif.reorder_tag_out, 0);
        chk("post_reset_data", bif.buffer_TDATA, 64'h41);
        drive_beat(64'h42, 1'b1);
        drain();
        chk("post_reset_outstanding", outstanding, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
